sc_pixel_sng_bank: RTL and testbench

SC_PIXEL_SNG_BANK -- requirements
Module: sc_pixel_sng_bank

---
 rtl/sc_pixel_sng_bank_if.sv | 22 ++
 rtl/sc_pixel_sng_bank.sv | 62 ++++++
 tb/tb_sc_pixel_sng_bank.sv | 116 +++++++++++
 3 files changed

// File: rtl/sc_pixel_sng_bank_if.sv
// sc_pixel_sng_bank_if: frame handshake, pixel input and stochastic bitstream bus of the SNG bank
interface sc_pixel_sng_bank_if #(
  parameter int N0 = 64,
  parameter int W  = 8
);
  logic            start;
  logic            start_ready;
  logic            abort;
  logic [N0*W-1:0] pixels;
  logic [N0-1:0]   sng_out;
  logic            sng_valid;
  logic            frame_first;
  logic            done;
  modport master (
    output start, abort, pixels,
    input  start_ready, sng_out, sng_valid, frame_first, done
  );
  modport slave (
    input  start, abort, pixels,
    output start_ready, sng_out, sng_valid, frame_first, done
  );
endinterface

// File: rtl/sc_pixel_sng_bank.sv
// sc_pixel_sng_bank: per-lane pixel-to-bitstream converters sharing one rotated 8-bit LFSR
module sc_pixel_sng_bank #(
  parameter int         N0   = 64,
  parameter int         W    = 8,
  parameter int         LEN  = 255,
  parameter logic [7:0] SEED = 8'hA5
) (
  input logic clk,
  input logic reset,
  sc_pixel_sng_bank_if.slave bus
);
  localparam int CW = $clog2(LEN + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N0*W-1:0] pix_q, pix_d;
  logic [15:0]     dbl;
  logic [N0-1:0]   cmp;
  logic            accept, run, last;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
    end
  end
  assign accept = state_q == IDLE && bus.start;
  assign run    = state_q == RUN;
  assign last   = cnt_q == CW'(LEN - 1);
  // abort takes priority over the last-cycle transition to DONE
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = bus.start ? RUN : IDLE;
      RUN:     state_d = bus.abort ? IDLE : last ? DONE : RUN;
      default: state_d = IDLE;
    endcase
    lfsr_d = accept ? SEED : run ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
    cnt_d  = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    pix_d  = accept ? bus.pixels : pix_q;
  end
  // lane i compares against the LFSR rotated left by i mod W, taken from a doubled copy
  assign dbl = {lfsr_q, lfsr_q};
  for (genvar i = 0; i < N0; i++) begin : g_lane
    localparam int K = i % W;
    assign cmp[i] = pix_q[i*W +: W] > dbl[15-K -: 8];
  end
  always_comb begin
    bus.start_ready = state_q == IDLE;
    bus.sng_valid   = run;
    bus.frame_first = run && cnt_q == '0;
    bus.done        = state_q == DONE;
    bus.sng_out     = run ? cmp : '0;
  end
endmodule

// File: tb/tb_sc_pixel_sng_bank.sv
// tb_sc_pixel_sng_bank: directed frames checked cycle by cycle against a bit-level LFSR/comparator model
module tb_sc_pixel_sng_bank;
  localparam int N0  = 16;
  localparam int W   = 8;
  localparam int LEN = 255;
  logic clk = 0;
  logic reset = 0;
  int cmp_n = 0;
  int err_n = 0;
  logic [N0*W-1:0] pa;
  byte unsigned vals [N0] = '{0, 1, 128, 255, 2, 254, 127, 64, 200, 17, 99, 3, 250, 5, 180, 77};
  always #5 clk = ~clk;
  sc_pixel_sng_bank_if #(.N0(N0), .W(W)) bus ();
  sc_pixel_sng_bank #(.N0(N0), .W(W), .LEN(LEN), .SEED(8'hA5)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, ".ready"}, bus.start_ready, 1);
    chk({tag, ".valid"}, bus.sng_valid, 0);
    chk({tag, ".sng"}, bus.sng_out, 0);
    chk({tag, ".first"}, bus.frame_first, 0);
    chk({tag, ".done"}, bus.done, 0);
  endtask
  function automatic logic [N0-1:0] model(input logic [N0*W-1:0] pix, input logic [7:0] l);
    logic [7:0] r;
    logic [N0-1:0] o;
    for (int i = 0; i < N0; i++) begin
      for (int j = 0; j < 8; j++) r[j] = l[(j - (i % 8) + 8) % 8];
      o[i] = pix[i*8 +: 8] > r;
    end
    return o;
  endfunction
  // mode 0: full frame, 1: abort at valid cycle stop_at, 2: reset at valid cycle stop_at
  task automatic frame(input logic [N0*W-1:0] pix, input int mode, input int stop_at, input bit hold, input bit cnt_ones);
    logic [7:0] l;
    int ones [N0];
    l = 8'hA5;
    for (int i = 0; i < N0; i++) ones[i] = 0;
    bus.pixels = pix;
    bus.start = 1;
    tick;
    if (!hold) bus.start = 0;
    for (int c = 0; c < LEN; c++) begin
      if (c == 3) bus.pixels = ~pix;
      chk("run.valid", bus.sng_valid, 1);
      chk("run.first", bus.frame_first, c == 0);
      chk("run.ready", bus.start_ready, 0);
      chk("run.done", bus.done, 0);
      chk("run.sng", bus.sng_out, model(pix, l));
      for (int i = 0; i < N0; i++) ones[i] += bus.sng_out[i];
      if (c == stop_at && mode == 1) bus.abort = 1;
      if (c == stop_at && mode == 2) reset = 0;
      tick;
      bus.abort = 0;
      reset = 1;
      if (mode != 0 && c == stop_at) begin
        idle_chk("stop");
        return;
      end
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    chk("end.done", bus.done, 1);
    chk("end.valid", bus.sng_valid, 0);
    chk("end.sng", bus.sng_out, 0);
    chk("end.ready", bus.start_ready, 0);
    chk("end.first", bus.frame_first, 0);
    if (cnt_ones)
      for (int i = 0; i < N0; i++)
        chk("ones", ones[i], pix[i*8 +: 8] > 0 ? pix[i*8 +: 8] - 1 : 0);
    tick;
    chk("back.ready", bus.start_ready, 1);
    chk("back.done", bus.done, 0);
  endtask
  initial begin
    bus.start = 1;
    bus.abort = 0;
    bus.pixels = '1;
    tick;
    idle_chk("rst0");
    tick;
    idle_chk("rst1");
    reset = 1;
    bus.start = 0;
    tick;
    idle_chk("post_rst");
    bus.abort = 1;
    tick;
    idle_chk("idle_abort");
    bus.abort = 0;
    for (int i = 0; i < N0; i++) pa[i*8 +: 8] = vals[i];
    frame('0, 0, 0, 0, 1);
    frame(pa, 0, 0, 0, 1);
    frame(pa, 0, 0, 1, 1);
    frame(pa, 0, 0, 0, 1);
    frame(pa, 1, 9, 0, 0);
    frame(pa, 0, 0, 0, 1);
    frame(pa, 1, LEN - 1, 0, 0);
    frame(pa, 2, 99, 0, 0);
    frame(pa, 0, 0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
